// File: rtl/instr_sequencer.sv
// ----------------------------------------------------------------------------
// instr_sequencer
//   Fetch/execute control FSM for the 8-bit core. It steps the external
//   program counter, fetches each instruction from instruction memory,
//   presents it to the decoder for a single execute cycle, and resolves
//   halt / ret / call / branch requests using an internal return stack.
//
// Ports
//   clk, rst            clock; synchronous active-high reset (shared with PC)
//   start               leave IDLE and begin fetching
//   pc_addr             current PC value
//   pc_en               PC increment strobe
//   pc_overwrite        PC load strobe
//   pc_overwrite_data   PC load value (0 whenever pc_overwrite is 0)
//   imem_req            instruction read request, address = pc_addr
//   imem_rdata          instruction read data
//   imem_valid          imem_rdata valid this cycle
//   instr               latched current instruction
//   instr_valid         execute-cycle strobe to the decoder
//   branch_req, call,   control requests from the decoder, sampled in EXEC
//   ret, halt
//   branch_target       jump/call destination
//   busy                state is FETCH or EXEC
//   halted              state is HALT
//   fault               sticky return-stack overflow/underflow
//
// Memory handshake: imem_req stays high for every FETCH cycle; the memory
// answers by raising imem_valid for one cycle with imem_rdata, which is
// captured on that edge. imem_valid is ignored in every other state, and
// there is no timeout while waiting.
// ----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int RS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_en,
  output logic               pc_overwrite,
  output logic [ADDR_W-1:0]  pc_overwrite_data,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               branch_req,
  input  logic               call,
  input  logic               ret,
  input  logic               halt,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               busy,
  output logic               halted,
  output logic               fault
);

  localparam int PTR_W = $clog2(RS_DEPTH);
  localparam logic [PTR_W:0] RS_FULL = (PTR_W+1)'(RS_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               fault_q, fault_d;
  // Stack count: 0 = empty, RS_DEPTH = full; one bit wider than the index.
  logic [PTR_W:0]     sp_q, sp_d;
  logic [ADDR_W-1:0]  rs_q [RS_DEPTH];

  logic               rs_push;
  logic [ADDR_W-1:0]  rs_push_data;
  logic [PTR_W:0]     sp_m1;
  logic               rs_empty;
  logic               rs_full;

  assign sp_m1    = sp_q - 1'b1;
  assign rs_empty = (sp_q == '0);
  assign rs_full  = (sp_q == RS_FULL);

  always_comb begin
    state_d           = state_q;
    instr_d           = instr_q;
    fault_d           = fault_q;
    sp_d              = sp_q;
    rs_push           = 1'b0;
    rs_push_data      = '0;
    pc_en             = 1'b0;
    pc_overwrite      = 1'b0;
    pc_overwrite_data = '0;
    imem_req          = 1'b0;
    instr_valid       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // Control inputs may be combinational from instr; exactly one PC
        // action (or none, when stopping) is issued, priority
        // halt > ret > call > branch_req > sequential.
        instr_valid = 1'b1;
        state_d     = ST_FETCH;
        if (halt) begin
          state_d = ST_HALT;
        end else if (ret) begin
          if (rs_empty) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else begin
            sp_d              = sp_m1;
            pc_overwrite      = 1'b1;
            pc_overwrite_data = rs_q[sp_m1[PTR_W-1:0]];
          end
        end else if (call) begin
          if (rs_full) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else begin
            rs_push           = 1'b1;
            rs_push_data      = pc_addr + ADDR_W'(1);  // wraps 0xFF -> 0x00
            sp_d              = sp_q + 1'b1;
            pc_overwrite      = 1'b1;
            pc_overwrite_data = branch_target;
          end
        end else if (branch_req) begin
          pc_overwrite      = 1'b1;
          pc_overwrite_data = branch_target;
        end else begin
          pc_en = 1'b1;
        end
      end

      ST_HALT: begin
        // Terminal until reset; start is ignored here.
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      fault_q <= 1'b0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      sp_q    <= sp_d;
    end
  end

  // Stack contents are not reset; only the count is meaningful.
  always_ff @(posedge clk) begin
    if (!rst && rs_push) rs_q[sp_q[PTR_W-1:0]] <= rs_push_data;
  end

  assign instr  = instr_q;
  assign fault  = fault_q;
  assign busy   = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign halted = (state_q == ST_HALT);

endmodule
